// File: rtl/expr_eval_if.sv
// expr_eval_if: request/result handshake bundle for expr_eval_pipe
interface expr_eval_if #(
  parameter int W = 6,
  parameter int LANES = 4
);
  logic in_valid, in_ready, sgn, clr_acc, out_valid, out_ready;
  logic [2:0] op;
  logic [LANES*W-1:0] a, b, y;
  logic [15:0] txn_count;
  modport master (
    output in_valid, op, sgn, a, b, clr_acc, out_ready,
    input in_ready, out_valid, y, txn_count
  );
  modport slave (
    input in_valid, op, sgn, a, b, clr_acc, out_ready,
    output in_ready, out_valid, y, txn_count
  );
endinterface

// File: rtl/expr_eval_pipe.sv
// expr_eval_pipe: two-stage multi-lane ALU pipeline with per-lane accumulators
module expr_eval_pipe #(
  parameter int W = 6,
  parameter int LANES = 4
) (
  input logic clk,
  input logic rst_n,
  expr_eval_if.slave bus
);
  localparam int N = LANES * W;
  logic s1_valid, s1_sgn, s2_ready, s1_adv, out_valid_q;
  logic [2:0] s1_op;
  logic [N-1:0] s1_a, s1_b, acc, acc_n, res, y_q;
  logic [15:0] txn_q;
  assign s2_ready = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_ready;
  assign s1_adv = s1_valid && s2_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y = y_q;
  assign bus.txn_count = txn_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] la, lb, base, sra;
    logic signed [W-1:0] sa;
    logic lt, rx;
    assign la = s1_a[i*W +: W];
    assign lb = s1_b[i*W +: W];
    assign sa = $signed(la);
    assign sra = sa >>> lb;
    assign lt = s1_sgn ? ($signed(la) < $signed(lb)) : (la < lb);
    assign rx = ~((^la) ^ (^lb));
    // a clear arriving with the ACC op discards the old value, so the op sees zero
    assign base = bus.clr_acc ? '0 : acc[i*W +: W];
    assign acc_n[i*W +: W] = base + la;
    assign res[i*W +: W] = s1_op == 3'd0 ? la + lb :
                           s1_op == 3'd1 ? la - lb :
                           s1_op == 3'd2 ? ~(la ^ lb) :
                           s1_op == 3'd3 ? (s1_sgn ? sra : la >> lb) :
                           s1_op == 3'd4 ? la << lb :
                           s1_op == 3'd5 ? {{(W-1){1'b0}}, lt} :
                           s1_op == 3'd6 ? {{(W-1){1'b0}}, rx} :
                                           acc_n[i*W +: W];
  end
  // S1: capture the request whenever the stage is free or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op <= '0;
      s1_sgn <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      s1_op <= bus.op;
      s1_sgn <= bus.sgn;
      s1_a <= bus.a;
      s1_b <= bus.b;
    end
  end
  // S2: register the computed result; hold while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q <= '0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid;
      if (s1_valid) y_q <= res;
    end
  end
  // accumulators advance only when an ACC op moves into S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (s1_adv && s1_op == 3'd7) acc <= acc_n;
    else if (bus.clr_acc) acc <= '0;
  end
  // saturating count of output handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) txn_q <= '0;
    else if (out_valid_q && bus.out_ready && txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
  end
endmodule
